hazard3_sd_mblk: RTL and testbench
==================================

// Module: hazard3_sd_mblk
// PURPOSE
//  APB-attached SD block-transfer controller: multi-block read/write between a word-addressable buffer and an
//  external byte-stream SD SPI engine (sd_controller handshake). Software loads LBA/COUNT, fills/drains the
//  buffer, kicks CMD, then polls STATUS or takes irq. Sits on the hazard3 example SoC APB bus.
// PARAMETERS
//  BLOCK_BYTES  512      bytes per SD block (power of 2, >=4)
//  NBLK         2        buffer depth in blocks; max COUNT per command
//  BUF_BASE     16'h0400 paddr offset of buffer window (aligned to NBLK*BLOCK_BYTES)
// PORTS
//  clk            in   1   clock
//  rst_n          in   1   asynchronous, active-low reset
//  psel,penable,pwrite in 1 APB control
//  paddr          in   16  APB byte address (offset)
//  pwdata         in   32  APB write data
//  prdata         out  32  APB read data
//  pready         out  1   APB ready
//  pslverr        out  1   APB error, valid with pready
//  irq            out  1   level interrupt = DONE & IRQ_EN
//  sd_rd,sd_wr    out  1   engine single-block read/write request
//  sd_addr        out  32  engine block address
//  sd_din         out  8   write byte;  sd_din_valid out 1;  sd_din_taken in 1
//  sd_dout        in   8   read byte;   sd_dout_avail in 1;  sd_dout_taken out 1
//  sd_busy,sd_error in 1   engine status;  sd_error_code in 3
// BEHAVIOUR
//  Reset (async): all outputs 0, FSM IDLE, LBA/COUNT/CTRL/STATUS 0. Buffer RAM contents not reset.
//  Registers: 0x00 CMD(W: b0 start, b1 dir 0=rd/1=wr, b2 irq_en, b3 abort; R: irq_en,dir); 0x04 LBA;
//   0x08 COUNT; 0x0C STATUS(R: b0 busy, b1 done, b2 err, [6:4] errcode, [15:8] blocks_done; W1C b1/b2).
//  Buffer: BUF_BASE..+NBLK*BLOCK_BYTES-1, 32-bit words, little-endian (byte0 = [7:0]); paddr[1:0] ignored.
//  APB: pready high exactly one cycle. Register access: pready 1 cycle after access phase. Buffer read: 2
//   cycles (sync RAM). Buffer write: 1 cycle. pready never asserted outside an access phase.
//  pslverr=1 (no state change): unmapped offset; CMD start while busy; start with COUNT==0 or COUNT>NBLK.
//  Buffer is dual-ported (APB port, engine port); APB buffer access legal while busy, never stalls.
//   Same-byte same-cycle writes: engine wins.
//  FSM: IDLE -> (start) ISSUE: sd_addr=LBA+k, slot k, byte index 0; wait !sd_busy, assert sd_rd or sd_wr.
//   Read: RD_WAIT (sd_dout_avail) -> store byte, sd_dout_taken=1 -> RD_ACK (wait !sd_dout_avail, taken=0,
//    idx++). idx==BLOCK_BYTES -> BLK_END.
//   Write: WR_FETCH (RAM read, 1 cycle) -> WR_PRESENT (sd_din, sd_din_valid=1, wait sd_din_taken,
//    valid=0) -> WR_ACK (wait !sd_din_taken, idx++). idx==BLOCK_BYTES -> BLK_END.
//   BLK_END: drop sd_rd/sd_wr, wait !sd_busy, blocks_done++, k++; k==COUNT -> DONE else ISSUE.
//   DONE: set done, busy=0 -> IDLE.
//  sd_rd/sd_wr held high for whole block (engine latches on rising edge); idx width log2(BLOCK_BYTES)+1.
//  sd_error in any non-IDLE state: drop requests/handshakes, err=1, errcode=sd_error_code, done=1,
//   blocks_done = completed blocks -> IDLE once !sd_busy.
//  Abort while busy: same as error with errcode=3'd7. Abort in IDLE: ignored, no error.
//  STATUS W1C of done while busy: ignored for busy. New start clears done/err/blocks_done.
//  LBA+k wraps modulo 2^32. Reset mid-transfer: immediate IDLE, requests dropped same edge.
// TESTING
//  1 Reset: check all outputs 0; STATUS read = 0 with pready after 1 wait cycle.
//  2 Buffer: write 0x44332211 @BUF_BASE, read back 0x44332211 (2 waits); @BUF_BASE+0x400 (NBLK=2) -> pslverr.
//  3 Read: LBA=0x10, COUNT=2, start rd; engine model returns bytes i&0xFF -> sd_addr 0x10 then 0x11,
//    buffer word0=0x03020100, word128=0x03020100, STATUS=0x0202, irq=1 if irq_en.
//  4 Write: fill slot0 with 0xA5, COUNT=1, start wr -> engine sees 512 bytes 0xA5, STATUS done, blocks_done=1.
//  5 Error: engine raises sd_error code 3'd2 after 100 bytes of block 1 of 2 -> STATUS 0x0126, requests low.
//  6 Misuse/abort: start while busy -> pslverr; COUNT=0 start -> pslverr; abort mid-block -> errcode 7, IDLE.

Source files
------------

// File: rtl/hazard3_sd_mblk_if.sv
// Bus bundle for the SD block-transfer controller: APB slave side plus the byte-stream
// handshake to the external SD SPI engine.
interface hazard3_sd_mblk_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        irq;
  logic        sd_rd;
  logic        sd_wr;
  logic [31:0] sd_addr;
  logic [7:0]  sd_din;
  logic        sd_din_valid;
  logic        sd_din_taken;
  logic [7:0]  sd_dout;
  logic        sd_dout_avail;
  logic        sd_dout_taken;
  logic        sd_busy;
  logic        sd_error;
  logic [2:0]  sd_error_code;

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr, irq,
    output sd_rd, sd_wr, sd_addr, sd_din, sd_din_valid, sd_dout_taken,
    input  sd_din_taken, sd_dout, sd_dout_avail, sd_busy, sd_error, sd_error_code
  );

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr, irq,
    input  sd_rd, sd_wr, sd_addr, sd_din, sd_din_valid, sd_dout_taken,
    output sd_din_taken, sd_dout, sd_dout_avail, sd_busy, sd_error, sd_error_code
  );
endinterface

// File: rtl/hazard3_sd_mblk.sv
// APB-attached SD multi-block transfer controller: moves whole blocks between a dual-ported
// word buffer and a byte-stream SD engine, with status polling and a level interrupt.
module hazard3_sd_mblk #(
  parameter int unsigned BLOCK_BYTES = 512,
  parameter int unsigned NBLK        = 2,
  parameter logic [15:0] BUF_BASE    = 16'h0400
) (
  input logic              clk,
  input logic              rst_n,
  hazard3_sd_mblk_if.slave bus
);

  localparam int unsigned IdxW  = $clog2(BLOCK_BYTES) + 1;
  localparam int unsigned AW    = $clog2(NBLK * BLOCK_BYTES);
  localparam int unsigned Words = NBLK * BLOCK_BYTES / 4;
  localparam int unsigned KW    = $clog2(NBLK + 1);

  typedef enum logic [3:0] {
    StIdle, StIssue, StRdWait, StRdAck, StWrFetch, StWrPresent, StWrAck, StBlkEnd, StDone, StErr
  } state_e;

  state_e              state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [31:0]         lba_q, lba_d, count_q, count_d, sd_addr_q, sd_addr_d;
  logic                dir_q, dir_d, irq_en_q, irq_en_d, done_q, done_d, err_q, err_d;
  logic [2:0]          errcode_q, errcode_d;
  logic [7:0]          blkdone_q, blkdone_d;
  logic                sd_rd_q, sd_rd_d, sd_wr_q, sd_wr_d, din_valid_q, din_valid_d;
  logic                dout_taken_q, dout_taken_d;
  logic                pready_q, pready_d, pslverr_q, pslverr_d, wcnt_q, wcnt_d;
  logic [31:0]         prdata_q, prdata_d, reg_rdata;

  logic [31:0]         mem [Words];
  logic [31:0]         apb_rdata_q, eng_rdata_q;
  logic [AW-1:0]       eng_baddr;
  logic [1:0]          eng_lane, reg_sel;
  logic                eng_we, eng_re, apb_we;
  logic                busy, acc, is_buf, is_reg, apb_err, commit, start, abort;
  logic                unused_paddr;

  assign busy     = (state_q != StIdle);
  assign is_buf   = (bus.paddr[15:AW] == BUF_BASE[15:AW]);
  assign is_reg   = (bus.paddr[15:4] == 12'h000);
  assign reg_sel  = bus.paddr[3:2];
  assign acc      = bus.psel && bus.penable && !pready_q;
  // Buffer reads need an extra cycle for the synchronous RAM port.
  assign commit   = acc && (!(is_buf && !bus.pwrite) || wcnt_q);
  assign apb_err  = (!is_buf && !is_reg) ||
                    (is_reg && bus.pwrite && reg_sel == 2'd0 && bus.pwdata[0] &&
                     (busy || count_q == 32'd0 || count_q > 32'(NBLK)));
  assign apb_we   = commit && bus.pwrite && is_buf;
  assign eng_baddr = (AW'(k_q) << $clog2(BLOCK_BYTES)) | AW'(idx_q[IdxW-2:0]);
  assign eng_lane  = eng_baddr[1:0];
  assign unused_paddr = ^bus.paddr[1:0];

  always_ff @(posedge clk) begin
    if (apb_we) mem[bus.paddr[AW-1:2]] <= bus.pwdata;
    // Engine byte write comes last so it wins a same-byte collision.
    for (int b = 0; b < 4; b++) begin
      if (eng_we && eng_lane == 2'(b)) mem[eng_baddr[AW-1:2]][8*b +: 8] <= bus.sd_dout;
    end
    apb_rdata_q <= mem[bus.paddr[AW-1:2]];
    if (eng_re) eng_rdata_q <= mem[eng_baddr[AW-1:2]];
  end

  always_comb begin
    reg_rdata = '0;
    unique case (reg_sel)
      2'd0:    reg_rdata = {29'd0, irq_en_q, dir_q, 1'b0};
      2'd1:    reg_rdata = lba_q;
      2'd2:    reg_rdata = count_q;
      default: reg_rdata = {16'd0, blkdone_q, 1'b0, errcode_q, 1'b0, err_q, done_q, busy};
    endcase
  end

  always_comb begin
    state_d = state_q;   k_d = k_q;             idx_d = idx_q;
    lba_d = lba_q;       count_d = count_q;     sd_addr_d = sd_addr_q;
    dir_d = dir_q;       irq_en_d = irq_en_q;   done_d = done_q;
    err_d = err_q;       errcode_d = errcode_q; blkdone_d = blkdone_q;
    sd_rd_d = sd_rd_q;   sd_wr_d = sd_wr_q;     din_valid_d = din_valid_q;
    dout_taken_d = dout_taken_q;
    eng_we = 1'b0;       eng_re = 1'b0;         start = 1'b0;  abort = 1'b0;
    pready_d  = commit;
    pslverr_d = commit && apb_err;
    wcnt_d    = acc && !commit;
    prdata_d  = '0;

    if (commit && !apb_err) begin
      if (bus.pwrite && is_reg) begin
        unique case (reg_sel)
          2'd0: begin
            irq_en_d = bus.pwdata[2];
            if (!busy) dir_d = bus.pwdata[1];
            start = bus.pwdata[0];
            abort = bus.pwdata[3] && busy;
          end
          2'd1: if (!busy) lba_d = bus.pwdata;
          2'd2: if (!busy) count_d = bus.pwdata;
          default: begin
            if (bus.pwdata[1]) done_d = 1'b0;
            if (bus.pwdata[2]) err_d = 1'b0;
          end
        endcase
      end else if (!bus.pwrite) begin
        prdata_d = is_buf ? apb_rdata_q : reg_rdata;
      end
    end

    unique case (state_q)
      StIdle: if (start) begin
        done_d = 1'b0;  err_d = 1'b0;  errcode_d = 3'd0;  blkdone_d = 8'd0;
        k_d = '0;  idx_d = '0;  state_d = StIssue;
      end
      StIssue: if (!bus.sd_busy) begin
        sd_addr_d = lba_q + 32'(k_q);
        if (dir_q) begin sd_wr_d = 1'b1; state_d = StWrFetch; end
        else       begin sd_rd_d = 1'b1; state_d = StRdWait;  end
      end
      StRdWait: if (bus.sd_dout_avail) begin
        eng_we = 1'b1;  dout_taken_d = 1'b1;  state_d = StRdAck;
      end
      StRdAck: if (!bus.sd_dout_avail) begin
        dout_taken_d = 1'b0;
        idx_d = idx_q + 1'b1;
        if (idx_d == IdxW'(BLOCK_BYTES)) begin sd_rd_d = 1'b0; state_d = StBlkEnd; end
        else state_d = StRdWait;
      end
      StWrFetch: begin
        eng_re = 1'b1;  din_valid_d = 1'b1;  state_d = StWrPresent;
      end
      StWrPresent: if (bus.sd_din_taken) begin
        din_valid_d = 1'b0;  state_d = StWrAck;
      end
      StWrAck: if (!bus.sd_din_taken) begin
        idx_d = idx_q + 1'b1;
        if (idx_d == IdxW'(BLOCK_BYTES)) begin sd_wr_d = 1'b0; state_d = StBlkEnd; end
        else state_d = StWrFetch;
      end
      StBlkEnd: if (!bus.sd_busy) begin
        blkdone_d = blkdone_q + 8'd1;
        k_d = k_q + 1'b1;
        idx_d = '0;
        state_d = (32'(k_d) == count_q) ? StDone : StIssue;
      end
      StDone: begin
        done_d = 1'b1;  state_d = StIdle;
      end
      StErr: if (!bus.sd_busy) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Engine error or software abort terminates the command from any active state.
    if (state_q != StIdle && state_q != StErr && (bus.sd_error || abort)) begin
      sd_rd_d = 1'b0;  sd_wr_d = 1'b0;  din_valid_d = 1'b0;  dout_taken_d = 1'b0;
      eng_we = 1'b0;   blkdone_d = blkdone_q;
      err_d = 1'b1;    done_d = 1'b1;
      errcode_d = bus.sd_error ? bus.sd_error_code : 3'd7;
      state_d = StErr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;   k_q <= '0;          idx_q <= '0;
      lba_q <= '0;         count_q <= '0;      sd_addr_q <= '0;
      dir_q <= 1'b0;       irq_en_q <= 1'b0;   done_q <= 1'b0;
      err_q <= 1'b0;       errcode_q <= '0;    blkdone_q <= '0;
      sd_rd_q <= 1'b0;     sd_wr_q <= 1'b0;    din_valid_q <= 1'b0;
      dout_taken_q <= 1'b0;
      pready_q <= 1'b0;    pslverr_q <= 1'b0;  wcnt_q <= 1'b0;  prdata_q <= '0;
    end else begin
      state_q <= state_d;  k_q <= k_d;         idx_q <= idx_d;
      lba_q <= lba_d;      count_q <= count_d; sd_addr_q <= sd_addr_d;
      dir_q <= dir_d;      irq_en_q <= irq_en_d; done_q <= done_d;
      err_q <= err_d;      errcode_q <= errcode_d; blkdone_q <= blkdone_d;
      sd_rd_q <= sd_rd_d;  sd_wr_q <= sd_wr_d; din_valid_q <= din_valid_d;
      dout_taken_q <= dout_taken_d;
      pready_q <= pready_d; pslverr_q <= pslverr_d; wcnt_q <= wcnt_d; prdata_q <= prdata_d;
    end
  end

  assign bus.prdata        = prdata_q;
  assign bus.pready        = pready_q;
  assign bus.pslverr       = pslverr_q;
  assign bus.irq           = done_q && irq_en_q;
  assign bus.sd_rd         = sd_rd_q;
  assign bus.sd_wr         = sd_wr_q;
  assign bus.sd_addr       = sd_addr_q;
  assign bus.sd_din_valid  = din_valid_q;
  assign bus.sd_din        = din_valid_q ? eng_rdata_q[{eng_lane, 3'b000} +: 8] : 8'h00;
  assign bus.sd_dout_taken = dout_taken_q;

endmodule

// File: tb/tb_hazard3_sd_mblk.sv
// Directed bench for hazard3_sd_mblk: APB register/buffer access, multi-block read and
// write through a byte-stream engine model, engine error, misuse and abort.
module tb_hazard3_sd_mblk;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard3_sd_mblk_if bus ();

  hazard3_sd_mblk #(
    .BLOCK_BYTES (512),
    .NBLK        (2),
    .BUF_BASE    (16'h0400)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_pass = 0;
  int n_total = 0;
  int eng_blk = 0, eng_bytes = 0, wr_bytes = 0, wr_bad = 0, n_addr = 0;
  int err_blk = -1, err_at = 0;
  logic [31:0] addr_log [4];
  logic [31:0] rdat;
  logic        perr;
  int          waits;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic apb(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic err, output int nwait);
    @(posedge clk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr; bus.paddr = addr; bus.pwdata = wdata;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    nwait = 0;
    while (!bus.pready && nwait < 16) begin
      nwait++;
      @(posedge clk); #1;
    end
    rdata = bus.prdata;
    err   = bus.pslverr;
    if (nwait >= 16) chk("apb_timeout", 32'(bus.pready), 32'd1);
    @(posedge clk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
  endtask

  task automatic apb_wr(input logic [15:0] addr, input logic [31:0] wdata);
    apb(1'b1, addr, wdata, rdat, perr, waits);
  endtask

  task automatic apb_rd(input logic [15:0] addr);
    apb(1'b0, addr, 32'd0, rdat, perr, waits);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      apb_rd(16'h000C);
      n++;
    end while (rdat[0] && n < 3000);
    if (rdat[0]) chk(tag, 32'(rdat[0]), 32'd0);
  endtask

  // SD engine model: one block per rising request, bytes i&0xFF on reads.
  initial begin : engine
    bus.sd_dout = '0; bus.sd_dout_avail = 1'b0; bus.sd_din_taken = 1'b0;
    bus.sd_busy = 1'b0; bus.sd_error = 1'b0; bus.sd_error_code = '0;
    forever begin
      @(negedge clk);
      if (rst_n && (bus.sd_rd || bus.sd_wr)) begin
        if (n_addr < 4) addr_log[n_addr] = bus.sd_addr;
        n_addr++;
        bus.sd_busy = 1'b1;
        for (int i = 0; i < 512; i++) begin
          if (bus.sd_rd) begin
            if (eng_blk == err_blk && i == err_at) begin
              bus.sd_error_code = 3'd2;
              bus.sd_error = 1'b1;
              break;
            end
            bus.sd_dout = 8'(i);
            bus.sd_dout_avail = 1'b1;
            while (!bus.sd_dout_taken && bus.sd_rd) @(negedge clk);
            bus.sd_dout_avail = 1'b0;
            while (bus.sd_dout_taken) @(negedge clk);
            eng_bytes++;
          end else if (bus.sd_wr) begin
            while (!bus.sd_din_valid && bus.sd_wr) @(negedge clk);
            if (!bus.sd_wr) break;
            wr_bytes++;
            if (bus.sd_din !== 8'hA5) wr_bad++;
            bus.sd_din_taken = 1'b1;
            do @(negedge clk); while (bus.sd_din_valid);
            bus.sd_din_taken = 1'b0;
          end else begin
            break;
          end
        end
        while (bus.sd_rd || bus.sd_wr) @(negedge clk);
        @(negedge clk);
        bus.sd_busy = 1'b0;
        bus.sd_error = 1'b0;
        eng_blk++;
      end
    end
  end

  initial begin : stimulus
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = '0; bus.pwdata = '0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    chk("rst_prdata", bus.prdata, 32'd0);
    chk("rst_ctl", 32'({bus.pready, bus.pslverr, bus.irq, bus.sd_rd, bus.sd_wr,
                        bus.sd_din_valid, bus.sd_dout_taken}), 32'd0);
    chk("rst_sd_addr", bus.sd_addr, 32'd0);
    chk("rst_sd_din", 32'(bus.sd_din), 32'd0);
    rst_n = 1'b1;
    apb_rd(16'h000C);
    chk("rst_status", rdat, 32'd0);
    chk("reg_waits", 32'(waits), 32'd1);
    chk("reg_slverr", 32'(perr), 32'd0);

    // Buffer access
    apb_wr(16'h0400, 32'h44332211);
    chk("buf_wr_waits", 32'(waits), 32'd1);
    apb_rd(16'h0400);
    chk("buf_rd", rdat, 32'h44332211);
    chk("buf_rd_waits", 32'(waits), 32'd2);
    apb_rd(16'h0403);
    chk("buf_rd_lowbits", rdat, 32'h44332211);
    apb_rd(16'h0800);
    chk("buf_oob_slverr", 32'(perr), 32'd1);
    apb_wr(16'h0010, 32'h1);
    chk("unmapped_slverr", 32'(perr), 32'd1);

    // Two-block read with irq enabled
    apb_wr(16'h0004, 32'h10);
    apb_wr(16'h0008, 32'd2);
    n_addr = 0;
    apb_wr(16'h0000, 32'h5);
    chk("rd_start_ok", 32'(perr), 32'd0);
    wait_idle("rd_timeout");
    chk("rd_nblk", 32'(n_addr), 32'd2);
    chk("rd_addr0", addr_log[0], 32'h10);
    chk("rd_addr1", addr_log[1], 32'h11);
    apb_rd(16'h0400);
    chk("rd_word0", rdat, 32'h03020100);
    apb_rd(16'h0600);
    chk("rd_word128", rdat, 32'h03020100);
    apb_rd(16'h05FC);
    chk("rd_word127", rdat, 32'hFFFEFDFC);
    apb_rd(16'h000C);
    chk("rd_status", rdat, 32'h0202);
    chk("rd_irq", 32'(bus.irq), 32'd1);
    apb_rd(16'h0000);
    chk("cmd_readback", rdat, 32'h4);
    apb_wr(16'h000C, 32'h2);
    chk("w1c_irq", 32'(bus.irq), 32'd0);
    apb_rd(16'h000C);
    chk("w1c_status", rdat, 32'h0200);

    // Single-block write of 0xA5
    for (int i = 0; i < 128; i++) apb_wr(16'h0400 + 16'(4 * i), 32'hA5A5A5A5);
    apb_wr(16'h0004, 32'h33);
    apb_wr(16'h0008, 32'd1);
    n_addr = 0;
    apb_wr(16'h0000, 32'h3);
    wait_idle("wr_timeout");
    chk("wr_nblk", 32'(n_addr), 32'd1);
    chk("wr_addr", addr_log[0], 32'h33);
    chk("wr_bytes", 32'(wr_bytes), 32'd512);
    chk("wr_bad_bytes", 32'(wr_bad), 32'd0);
    apb_rd(16'h000C);
    chk("wr_status", rdat, 32'h0102);
    chk("wr_irq_off", 32'(bus.irq), 32'd0);

    // Engine error in the second block after 100 bytes
    apb_wr(16'h0004, 32'h20);
    apb_wr(16'h0008, 32'd2);
    eng_blk = 0; err_blk = 1; err_at = 100; n_addr = 0;
    apb_wr(16'h0000, 32'h1);
    wait_idle("err_timeout");
    err_blk = -1;
    chk("err_status", rdat, 32'h0126);
    chk("err_addr1", addr_log[1], 32'h21);
    chk("err_req_low", 32'({bus.sd_rd, bus.sd_wr, bus.sd_dout_taken}), 32'd0);

    // Misuse and abort
    apb_wr(16'h0008, 32'd0);
    apb_wr(16'h0000, 32'h1);
    chk("count0_slverr", 32'(perr), 32'd1);
    apb_rd(16'h000C);
    chk("count0_nochange", rdat, 32'h0126);
    apb_wr(16'h0008, 32'd3);
    apb_wr(16'h0000, 32'h1);
    chk("count3_slverr", 32'(perr), 32'd1);
    apb_wr(16'h0008, 32'd1);
    eng_bytes = 0;
    apb_wr(16'h0000, 32'h5);
    for (int c = 0; c < 2000 && eng_bytes < 10; c++) @(posedge clk);
    #1;
    chk("abort_progress", 32'(eng_bytes >= 10), 32'd1);
    apb_wr(16'h0000, 32'h1);
    chk("busy_start_slverr", 32'(perr), 32'd1);
    apb_rd(16'h000C);
    chk("busy_status", rdat, 32'h0001);
    apb_wr(16'h000C, 32'h6);
    apb_rd(16'h000C);
    chk("busy_w1c_status", rdat, 32'h0001);
    apb_wr(16'h0000, 32'hC);
    chk("abort_ok", 32'(perr), 32'd0);
    wait_idle("abort_timeout");
    chk("abort_status", rdat, 32'h0076);
    chk("abort_irq", 32'(bus.irq), 32'd1);
    chk("abort_rd_low", 32'(bus.sd_rd), 32'd0);
    apb_wr(16'h0000, 32'h8);
    chk("idle_abort_ok", 32'(perr), 32'd0);
    apb_rd(16'h000C);
    chk("idle_abort_status", rdat, 32'h0076);
    chk("idle_abort_irq", 32'(bus.irq), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
